button_step_ctrl: RTL and testbench

BUTTON_STEP_CTRL -- requirements
Module: button_step_ctrl

---
 rtl/button_step_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_button_step_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_step_ctrl.sv
// -----------------------------------------------------------------------------
// button_step_ctrl
//
// Turns two raw pushbuttons (up / down) into single-cycle step pulses for a
// downstream up/down counter. Each button is synchronised, then debounced, and
// a small FSM decides when to step and in which direction. Pressing both
// buttons together locks stepping out until both are released.
//
// Optional feature:
//   AUTO_REPEAT_BUTTON_EN  when defined, a held button auto-repeats: first
//                          repeat REPEAT_DELAY cycles after the initial step,
//                          then one step every REPEAT_RATE cycles. When it is
//                          undefined, the repeat timer is not built and each
//                          press gives exactly one step.
//
// Parameters:
//   DEBOUNCE_CYC  stable synchronised samples needed to change a level (>=1)
//   REPEAT_DELAY  cycles from first step to first repeat step          (>=2)
//   REPEAT_RATE   cycles between successive repeat steps               (>=2)
//
// Ports:
//   clk       in   clock, everything updates on the rising edge
//   reset     in   synchronous, active-high
//   btn_up    in   raw asynchronous up button, active-high
//   btn_down  in   raw asynchronous down button, active-high
//   step_en   out  one-cycle step pulse (downstream counter en)
//   step_up   out  direction of the most recent step, 1 = up
//   held      out  high in HELD_UP, HELD_DN or LOCKOUT
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no button held, waiting for a clean single press
// S_HELD_UP | up held alone, first step issued (repeats if enabled)
// S_HELD_DN | down held alone, first step issued (repeats if enabled)
// S_LOCKOUT | both buttons seen together, no steps until both released
// -----------------------------------------------------------------------------
module button_step_ctrl #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic step_en,
    output logic step_up,
    output logic held
);

    generate
        if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
            $error("button_step_ctrl: parameter out of range");
        end
    endgenerate

    localparam int             CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HELD_UP = 2'd1,
        S_HELD_DN = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    // Bit 0 = up button, bit 1 = down button throughout.
    logic [1:0]    r_meta;
    logic [1:0]    r_sync;
    logic [1:0]    r_deb;
    logic [CW-1:0] r_cnt [2];

    state_t r_state;
    state_t w_state_nxt;
    logic   r_step_en;
    logic   r_step_up;
    logic   r_held;
    logic   w_step_en_nxt;
    logic   w_step_up_nxt;
    logic   w_up;
    logic   w_dn;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {btn_down, btn_up};
            r_sync <= r_meta;
        end
    end

    // The counter only runs while the synchronised input disagrees with the
    // debounced level; any agreeing sample throws the partial count away, so
    // a glitch shorter than DEBOUNCE_CYC samples never reaches the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb    <= '0;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_sync[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_up = r_deb[0];
    assign w_dn = r_deb[1];

`ifdef AUTO_REPEAT_BUTTON_EN
    localparam int            RPT_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            TW         = $clog2(RPT_MAX);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

    logic [TW-1:0] r_rpt_tmr;
    logic [TW-1:0] w_rpt_tmr_nxt;
    // Set once the first repeat step has fired; selects the shorter period.
    logic          r_rpt_armed;
    logic          w_rpt_armed_nxt;
    logic          w_rpt_hit;

    assign w_rpt_hit = (r_rpt_tmr == (r_rpt_armed ? RATE_LAST : DELAY_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpt_tmr   <= '0;
            r_rpt_armed <= 1'b0;
        end else begin
            r_rpt_tmr   <= w_rpt_tmr_nxt;
            r_rpt_armed <= w_rpt_armed_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_step_en_nxt = 1'b0;
        w_step_up_nxt = r_step_up;
`ifdef AUTO_REPEAT_BUTTON_EN
        w_rpt_tmr_nxt   = r_rpt_tmr;
        w_rpt_armed_nxt = r_rpt_armed;
`endif
        case (r_state)
            S_IDLE: begin
                // Both high here can only mean they rose together.
                if (w_up && w_dn) begin
                    w_state_nxt = S_LOCKOUT;
                end else if (w_up || w_dn) begin
                    w_state_nxt   = w_up ? S_HELD_UP : S_HELD_DN;
                    w_step_en_nxt = 1'b1;
                    w_step_up_nxt = w_up;
`ifdef AUTO_REPEAT_BUTTON_EN
                    w_rpt_tmr_nxt   = '0;
                    w_rpt_armed_nxt = 1'b0;
`endif
                end
            end
            S_HELD_UP, S_HELD_DN: begin
                if ((r_state == S_HELD_UP) ? w_dn : w_up) begin
                    w_state_nxt = S_LOCKOUT;
                end else if (!((r_state == S_HELD_UP) ? w_up : w_dn)) begin
                    w_state_nxt = S_IDLE;
                end else begin
`ifdef AUTO_REPEAT_BUTTON_EN
                    if (w_rpt_hit) begin
                        w_step_en_nxt   = 1'b1;
                        w_step_up_nxt   = (r_state == S_HELD_UP);
                        w_rpt_tmr_nxt   = '0;
                        w_rpt_armed_nxt = 1'b1;
                    end else begin
                        w_rpt_tmr_nxt = r_rpt_tmr + 1'b1;
                    end
`endif
                end
            end
            S_LOCKOUT: begin
                if (!w_up && !w_dn) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_step_en <= 1'b0;
            r_step_up <= 1'b1;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step_en <= w_step_en_nxt;
            r_step_up <= w_step_up_nxt;
            r_held    <= (w_state_nxt != S_IDLE);
        end
    end

    assign step_en = r_step_en;
    assign step_up = r_step_up;
    assign held    = r_held;

endmodule

// File: tb/tb_button_step_ctrl.sv
module tb_button_step_ctrl;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 5;
`ifdef AUTO_REPEAT_BUTTON_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_up;
    logic btn_down;
    logic step_en;
    logic step_up;
    logic held;

    always #5 clk = ~clk;

    button_step_ctrl #(
        .DEBOUNCE_CYC (D),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .step_en  (step_en),
        .step_up  (step_up),
        .held     (held)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: raw button history indexed by edge number, debounced
    // level derived from "last D synchronised samples all disagree", and the
    // step decisions from elapsed-cycle arithmetic since the last step.
    bit raw_u [0:8191];
    bit raw_d [0:8191];
    int e     = 0;
    int rst_e = 0;
    bit m_deb_u, m_deb_d;
    int m_mode;          // 0 idle, 1 up held, 2 down held, 3 locked out
    int m_since, m_nrep;
    bit m_step;
    bit m_dir = 1'b1;
    bit m_held;
    bit prev_step;
    int steps, first, second;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, e);
        end
    endtask

    // Value the debouncer sees at edge k: raw sampled two edges earlier,
    // zero if that sample precedes (or is) the last reset edge.
    function automatic bit seen(input bit is_up, input int k);
        if (k - 2 <= rst_e || k - 2 < 0) return 1'b0;
        return is_up ? raw_u[k-2] : raw_d[k-2];
    endfunction

    function automatic bit flips(input bit is_up, input bit deb);
        for (int j = 0; j < D; j++)
            if (seen(is_up, e - j) == deb) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit up, input bit dn, input bit rst);
        bit u, d;
        e++;
        raw_u[e] = up;
        raw_d[e] = dn;
        m_step = 1'b0;
        if (rst) begin
            rst_e   = e;
            m_deb_u = 1'b0;
            m_deb_d = 1'b0;
            m_mode  = 0;
            m_since = 0;
            m_nrep  = 0;
            m_dir   = 1'b1;
        end else begin
            u = m_deb_u;
            d = m_deb_d;
            case (m_mode)
                0: begin
                    if (u && d) m_mode = 3;
                    else if (u || d) begin
                        m_mode  = u ? 1 : 2;
                        m_step  = 1'b1;
                        m_dir   = u;
                        m_since = 0;
                        m_nrep  = 0;
                    end
                end
                1, 2: begin
                    if ((m_mode == 1 && d) || (m_mode == 2 && u)) m_mode = 3;
                    else if ((m_mode == 1 && !u) || (m_mode == 2 && !d)) m_mode = 0;
                    else begin
                        m_since++;
                        if (RPT && m_since == ((m_nrep == 0) ? RD : RR)) begin
                            m_step  = 1'b1;
                            m_since = 0;
                            m_nrep++;
                        end
                    end
                end
                default: if (!u && !d) m_mode = 0;
            endcase
            if (flips(1'b1, m_deb_u)) m_deb_u = !m_deb_u;
            if (flips(1'b0, m_deb_d)) m_deb_d = !m_deb_d;
        end
        m_held = (m_mode != 0);
    endtask

    // One clock: drive, take the edge, sample 1 time unit later, compare.
    task automatic cyc(input bit up, input bit dn, input bit rst);
        btn_up   = up;
        btn_down = dn;
        reset    = rst;
        @(posedge clk);
        #1;
        model_edge(up, dn, rst);
        chk("step_en", 32'(step_en), 32'(m_step));
        chk("step_up", 32'(step_up), 32'(m_dir));
        chk("held",    32'(held),    32'(m_held));
        chk("no_b2b",  32'(prev_step & step_en), 32'd0);
        prev_step = step_en;
    endtask

    task automatic note_step(input int idx);
        if (step_en) begin
            steps++;
            if (first < 0) first = idx;
            else if (second < 0) second = idx;
        end
    endtask

    task automatic start_case();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        steps  = 0;
        first  = -1;
        second = -1;
    endtask

    bit r_up, r_dn, r_rst;
    int r_len;

    initial begin
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        reset     = 1'b1;
        prev_step = 1'b0;

        // Reset state
        start_case();
        chk("rst_step_en", 32'(step_en), 32'd0);
        chk("rst_step_up", 32'(step_up), 32'd1);
        chk("rst_held",    32'(held),    32'd0);

        // Clean up press of 10 cycles, then release
        start_case();
        for (int i = 1; i <= 10; i++) begin cyc(1'b1, 1'b0, 1'b0); note_step(i); end
        chk("s1_held", 32'(held), 32'd1);
        for (int i = 11; i <= 25; i++) begin cyc(1'b0, 1'b0, 1'b0); note_step(i); end
        chk("s1_first_step", first, D + 3);
        chk("s1_steps",      steps, 1);
        chk("s1_released",   32'(held), 32'd0);

        // 3-cycle glitch on down
        start_case();
        for (int i = 1; i <= 3; i++)  begin cyc(1'b0, 1'b1, 1'b0); note_step(i); end
        for (int i = 4; i <= 15; i++) begin cyc(1'b0, 1'b0, 1'b0); note_step(i); end
        chk("s2_steps",  steps, 0);
        chk("s2_deb_dn", 32'(dut.r_deb[1]), 32'd0);

        // Long hold of up for 50 cycles
        start_case();
        for (int i = 1; i <= 50; i++) begin cyc(1'b1, 1'b0, 1'b0); note_step(i); end
        for (int i = 51; i <= 70; i++) begin cyc(1'b0, 1'b0, 1'b0); note_step(i); end
        chk("s3_first",  first,  7);
        chk("s3_second", second, RPT ? 27 : -1);
        chk("s3_steps",  steps,  RPT ? 7 : 1);

        // Both together, release up first, then both
        start_case();
        for (int i = 1; i <= 10; i++)  begin cyc(1'b1, 1'b1, 1'b0); note_step(i); end
        chk("s4_lock_held", 32'(held), 32'd1);
        for (int i = 11; i <= 20; i++) begin cyc(1'b0, 1'b1, 1'b0); note_step(i); end
        chk("s4_still_held", 32'(held), 32'd1);
        for (int i = 21; i <= 35; i++) begin cyc(1'b0, 1'b0, 1'b0); note_step(i); end
        chk("s4_idle",  32'(held), 32'd0);
        chk("s4_steps", steps, 0);

        // Up held, down pressed at cycle 15 -> lockout before first repeat
        start_case();
        for (int i = 1; i <= 35; i++)  begin cyc(1'b1, (i >= 15), 1'b0); note_step(i); end
        for (int i = 36; i <= 50; i++) begin cyc(1'b0, 1'b0, 1'b0); note_step(i); end
        chk("s5_steps", steps, 1);

        // Reset pulse on what would be a repeat step, button still held
        start_case();
        for (int i = 1; i <= 31; i++) begin cyc(1'b1, 1'b0, 1'b0); note_step(i); end
        cyc(1'b1, 1'b0, 1'b1);
        chk("s6_rst_step", 32'(step_en), 32'd0);
        steps  = 0;
        first  = -1;
        second = -1;
        for (int i = 1; i <= 12; i++) begin cyc(1'b1, 1'b0, 1'b0); note_step(i); end
        chk("s6_fresh_step", first, D + 3);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);

        // Random segments: holds, short glitches, chords, occasional reset
        for (int b = 0; b < 90; b++) begin
            r_up  = ($urandom_range(0, 1) == 1);
            r_dn  = ($urandom_range(0, 2) == 0);
            r_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D)) : int'($urandom_range(1, 40));
            r_rst = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < r_len; i++) cyc(r_up, r_dn, 1'b0);
            if (r_rst) cyc(r_up, r_dn, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
